dotprod_l2_cfu: RTL and testbench

Variable-latency (CFU-L2) stateful, serializable dot-product CFU: the multi-context, handshaked successor to our fixed-latency dot-product unit. It reduces `CFU_DATA_W/ELEM_W` element products over several cycles, `LANES` products per cycle, and adds signed-element functions. It keeps per-context accumulators with full IStateContext status/state access. It sits behind a CFU-L2 mux/adapter, which provides and consumes valid/ready on both request and response.

---
 rtl/cfu_pkg.sv | 62 ++++++
 rtl/dotprod_l2_cfu_lanes.sv | 39 +++
 rtl/dotprod_l2_cfu.sv | 181 ++++++++++++++++++
 tb/tb_dotprod_l2_cfu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cfu_pkg.sv
// rtl/cfu_pkg.sv - CFU-L2 shared types: function IDs, status, context state and CSW
package cfu_pkg;

    typedef logic [9:0] cfid_t;

    typedef enum logic [9:0] {
        CFU_WRITE_STATE  = 10'd1020,
        CFU_READ_STATE   = 10'd1021,
        CFU_WRITE_STATUS = 10'd1022,
        CFU_READ_STATUS  = 10'd1023
    } istate_cfid_t;

    typedef enum logic [9:0] {
        DOTPROD_DOTPROD     = 10'd0,
        DOTPROD_DOTPRODACC  = 10'd1,
        DOTPROD_SDOTPROD    = 10'd2,
        DOTPROD_SDOTPRODACC = 10'd3
    } dotprod_cfid_t;

    typedef enum logic [2:0] {
        CFU_OK           = 3'd0,
        CFU_ERROR_CFU    = 3'd1,
        CFU_ERROR_OFF    = 3'd2,
        CFU_ERROR_STATE  = 3'd3,
        CFU_ERROR_INSN   = 3'd4,
        CFU_ERROR_FUNC   = 3'd5,
        CFU_ERROR_OP     = 3'd6,
        CFU_ERROR_CUSTOM = 3'd7
    } cfu_status_t;

    typedef enum logic [1:0] {
        CFU_CS_OFF   = 2'd0,
        CFU_CS_INIT  = 2'd1,
        CFU_CS_CLEAN = 2'd2,
        CFU_CS_DIRTY = 2'd3
    } cfu_cs_t;

    typedef struct packed {
        logic [23:0] state_size;
        logic [5:0]  rsvd;
        cfu_cs_t     cs;
    } cfu_csw_t;

    typedef enum logic [1:0] {
        DP_IDLE = 2'd0,
        DP_BUSY = 2'd1,
        DP_RESP = 2'd2
    } dp_state_e;

    function automatic logic is_dot_func(input cfid_t f);
        return f[9:2] == 8'd0;
    endfunction

    function automatic logic is_istate_func(input cfid_t f);
        return f[9:2] == 8'hFF;
    endfunction

    function automatic logic is_status_func(input cfid_t f);
        return (f == CFU_WRITE_STATUS) || (f == CFU_READ_STATUS);
    endfunction

endpackage

// File: rtl/dotprod_l2_cfu_lanes.sv
// rtl/dotprod_l2_cfu_lanes.sv - combinational LANES-wide multiply and reduce
module dotprod_lanes #(
    parameter int ELEM_W = 8,
    parameter int LANES  = 1,
    parameter int DOTP_W = 18
) (
    input  logic [LANES*ELEM_W-1:0] a_i,
    input  logic [LANES*ELEM_W-1:0] b_i,
    input  logic                    signed_en_i,
    output logic [DOTP_W-1:0]       sum_o
);

    localparam int PW = 2*ELEM_W + 2;
    localparam int SW = (DOTP_W > PW) ? DOTP_W : PW;

    logic [ELEM_W-1:0] ea, eb;
    logic signed [PW-1:0] pa, pb, prod;
    logic signed [SW-1:0] acc;

    // One extra operand bit makes unsigned and signed products share one multiplier.
    always_comb begin
        ea   = '0;
        eb   = '0;
        pa   = '0;
        pb   = '0;
        prod = '0;
        acc  = '0;
        for (int i = 0; i < LANES; i++) begin
            ea   = a_i[i*ELEM_W +: ELEM_W];
            eb   = b_i[i*ELEM_W +: ELEM_W];
            pa   = {{(ELEM_W+2){signed_en_i & ea[ELEM_W-1]}}, ea};
            pb   = {{(ELEM_W+2){signed_en_i & eb[ELEM_W-1]}}, eb};
            prod = pa * pb;
            acc  = acc + SW'(prod);
        end
        sum_o = acc[DOTP_W-1:0];
    end

endmodule

// File: rtl/dotprod_l2_cfu.sv
// rtl/dotprod_l2_cfu.sv - multi-context handshaked dot-product CFU with state/status access
module dotprod_l2_cfu
    import cfu_pkg::*;
#(
    parameter int CFU_N_STATES   = 4,
    parameter int CFU_FUNC_ID_W  = 10,
    parameter int CFU_DATA_W     = 32,
    parameter int CFU_CFU_ID_W   = 1,
    parameter int CFU_STATE_ID_W = (CFU_N_STATES > 1) ? $clog2(CFU_N_STATES) : 1,
    parameter int ELEM_W         = 8,
    parameter int LANES          = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CFU_CFU_ID_W-1:0]   req_cfu,
    input  logic [CFU_STATE_ID_W-1:0] req_state,
    input  logic [CFU_FUNC_ID_W-1:0]  req_func,
    input  logic [CFU_DATA_W-1:0]     req_data0,
    input  logic [CFU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output cfu_status_t               resp_status,
    output logic [CFU_DATA_W-1:0]     resp_data
);

    localparam int NE       = CFU_DATA_W / ELEM_W;
    localparam int K        = NE / LANES;
    localparam int DOTP_RAW = 2*ELEM_W + $clog2(NE);
    localparam int DOTP_W   = (DOTP_RAW < CFU_DATA_W) ? DOTP_RAW : CFU_DATA_W;
    localparam int GRP_W    = LANES * ELEM_W;
    localparam int NCTX     = 1 << CFU_STATE_ID_W;
    localparam int CNT_W    = (K > 1) ? $clog2(K) : 1;

    dp_state_e                 state_q, state_d;
    cfid_t                     func_q;
    logic [CFU_STATE_ID_W-1:0] sidx_q;
    logic [CFU_DATA_W-1:0]     a_q, b_q, data_q;
    logic [DOTP_W-1:0]         psum_q;
    logic [CNT_W-1:0]          cnt_q;
    cfu_status_t               status_q;
    cfu_cs_t                   cs_q [NCTX];
    logic [NCTX-1:0]           zacc_q;
    logic [CFU_DATA_W-1:0]     acc_q [NCTX];

    cfid_t                     func_in;
    logic                      accept, busy_last, acc_we;
    cfu_status_t               err;
    logic [DOTP_W-1:0]         lane_sum, psum_n;
    logic [CFU_DATA_W-1:0]     dot_ext, acc_old, dot_res, acc_wdata, csw_data;
    logic [CFU_STATE_ID_W-1:0] acc_widx;
    cfu_csw_t                  csw;
    cfu_cs_t                   new_cs;
    logic                      unused_req_cfu;

    assign unused_req_cfu = ^req_cfu;
    assign func_in    = cfid_t'(req_func);
    assign req_ready  = !rst && ((state_q == DP_IDLE) || ((state_q == DP_RESP) && resp_ready));
    assign accept     = req_valid && req_ready && clk_en;
    assign busy_last  = !rst && clk_en && (state_q == DP_BUSY) && (32'(cnt_q) == K - 1);
    assign resp_valid = (state_q == DP_RESP);
    assign resp_status = status_q;
    assign resp_data  = data_q;

    always_comb begin
        err = CFU_OK;
        if (32'(req_state) >= CFU_N_STATES)
            err = CFU_ERROR_STATE;
        else if ((cs_q[req_state] == CFU_CS_OFF) && !is_status_func(func_in))
            err = CFU_ERROR_OFF;
        else if (!is_dot_func(func_in) && !is_istate_func(func_in))
            err = CFU_ERROR_FUNC;
    end

    dotprod_lanes #(.ELEM_W(ELEM_W), .LANES(LANES), .DOTP_W(DOTP_W)) u_lanes (
        .a_i         (a_q[GRP_W-1:0]),
        .b_i         (b_q[GRP_W-1:0]),
        .signed_en_i (func_q[1]),
        .sum_o       (lane_sum)
    );

    // func[1] selects signed elements, func[0] selects accumulate.
    assign psum_n  = psum_q + lane_sum;
    assign dot_ext = func_q[1] ? CFU_DATA_W'($signed(psum_n)) : CFU_DATA_W'(psum_n);
    assign acc_old = zacc_q[sidx_q] ? '0 : acc_q[sidx_q];
    assign dot_res = func_q[0] ? (acc_old + dot_ext) : dot_ext;
    assign csw      = '{state_size: 24'd1, rsvd: 6'd0, cs: cs_q[req_state]};
    assign csw_data = CFU_DATA_W'(csw);
    assign new_cs   = cfu_cs_t'(req_data0[1:0]);

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = ((err == CFU_OK) && is_dot_func(func_in)) ? DP_BUSY : DP_RESP;
        else if (clk_en) begin
            case (state_q)
                DP_BUSY: if (busy_last) state_d = DP_RESP;
                DP_RESP: if (resp_ready) state_d = DP_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= DP_IDLE;
        else if (clk_en)
            state_q <= state_d;
    end

    always_comb begin
        acc_we    = busy_last;
        acc_wdata = dot_res;
        acc_widx  = sidx_q;
        if (accept && (err == CFU_OK) && (func_in == CFU_WRITE_STATE)) begin
            acc_we    = 1'b1;
            acc_wdata = req_data0;
            acc_widx  = req_state;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_we)
            acc_q[acc_widx] <= acc_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= CFU_OK;
            data_q   <= '0;
            zacc_q   <= '1;
            for (int i = 0; i < NCTX; i++)
                cs_q[i] <= CFU_CS_INIT;
        end else if (clk_en) begin
            if (accept) begin
                func_q   <= func_in;
                sidx_q   <= req_state;
                a_q      <= req_data0;
                b_q      <= req_data1;
                cnt_q    <= '0;
                psum_q   <= '0;
                status_q <= err;
                data_q   <= '0;
                if (err == CFU_OK) begin
                    case (func_in)
                        CFU_WRITE_STATE: begin
                            cs_q[req_state]   <= CFU_CS_DIRTY;
                            zacc_q[req_state] <= 1'b0;
                            data_q            <= req_data0;
                        end
                        CFU_READ_STATE:
                            data_q <= zacc_q[req_state] ? '0 : acc_q[req_state];
                        CFU_WRITE_STATUS: begin
                            data_q          <= csw_data;
                            cs_q[req_state] <= new_cs;
                            if ((new_cs == CFU_CS_OFF) || (new_cs == CFU_CS_INIT))
                                zacc_q[req_state] <= 1'b1;
                        end
                        CFU_READ_STATUS:
                            data_q <= csw_data;
                        default: ;
                    endcase
                end
            end else if (state_q == DP_BUSY) begin
                psum_q <= psum_n;
                cnt_q  <= cnt_q + 1'b1;
                a_q    <= a_q >> GRP_W;
                b_q    <= b_q >> GRP_W;
                if (busy_last) begin
                    cs_q[sidx_q]   <= CFU_CS_DIRTY;
                    zacc_q[sidx_q] <= 1'b0;
                    data_q         <= dot_res;
                    status_q       <= CFU_OK;
                end
            end
        end
    end

endmodule

// File: tb/tb_dotprod_l2_cfu.sv
// tb/tb_dotprod_l2_cfu.sv - directed self-checking bench for dotprod_l2_cfu
module tb_dotprod_l2_cfu;
    import cfu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clk_en, req_valid, resp_ready;
    logic [0:0]  req_cfu;
    logic [2:0]  req_state;
    logic [9:0]  req_func;
    logic [31:0] req_data0, req_data1;
    logic        req_ready, resp_valid;
    cfu_status_t resp_status;
    logic [31:0] resp_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dotprod_l2_cfu #(
        .CFU_N_STATES(4), .CFU_FUNC_ID_W(10), .CFU_DATA_W(32), .CFU_CFU_ID_W(1),
        .CFU_STATE_ID_W(3), .ELEM_W(8), .LANES(1)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_cfu(req_cfu),
        .req_state(req_state), .req_func(req_func),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_data(resp_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [9:0] f, input logic [2:0] s,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] exp_data, input cfu_status_t exp_st, input int exp_lat);
        int lat;
        @(negedge clk);
        req_func = f; req_state = s; req_data0 = d0; req_data1 = d1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_status"}, 64'(resp_status), 64'(exp_st));
        check_eq({tag, "_data"}, 64'(resp_data), 64'(exp_data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        req_cfu = 1'b0; req_state = '0; req_func = '0; req_data0 = '0; req_data1 = '0;

        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_eq("rst_resp_status", 64'(resp_status), 64'(CFU_OK));
        check_eq("rst_resp_data", 64'(resp_data), 64'(0));
        rst = 1'b0;
        #1 check_eq("post_rst_req_ready", 64'(req_ready), 64'(1));

        // 4*8 + 3*7 + 2*6 + 1*5 = 70
        txn("dotprod", 10'd0, 3'd0, 32'h01020304, 32'h05060708, 32'h46, CFU_OK, 5);
        txn("rdstat_dirty", 10'd1023, 3'd0, 32'h0, 32'h0, 32'h103, CFU_OK, 1);

        do_reset();
        txn("acc1", 10'd1, 3'd0, 32'h01020304, 32'h05060708, 32'h46, CFU_OK, 5);
        txn("acc2", 10'd1, 3'd0, 32'h01020304, 32'h05060708, 32'h8C, CFU_OK, 5);
        txn("rdstate_s1", 10'd1021, 3'd1, 32'h0, 32'h0, 32'h0, CFU_OK, 1);

        txn("sdotprod", 10'd2, 3'd0, 32'hFFFFFFFF, 32'h01010101, 32'hFFFFFFFC, CFU_OK, 5);
        txn("udotprod", 10'd0, 3'd0, 32'hFFFFFFFF, 32'h01010101, 32'h3FC, CFU_OK, 5);

        // Backpressure, then a queued request accepted on the handshake cycle.
        @(negedge clk);
        req_func = 10'd1020; req_state = 3'd2; req_data0 = 32'h12345678; req_data1 = '0;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_func = 10'd1023; req_data0 = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 64'(resp_valid), 64'(1));
            check_eq("stall_data", 64'(resp_data), 64'h12345678);
            check_eq("stall_status", 64'(resp_status), 64'(CFU_OK));
            check_eq("stall_req_ready", 64'(req_ready), 64'(0));
        end
        resp_ready = 1'b1;
        #1 check_eq("release_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_valid", 64'(resp_valid), 64'(1));
        check_eq("b2b_data", 64'(resp_data), 64'h103);
        @(posedge clk);
        #1;

        txn("err_state", 10'd0, 3'd5, 32'h01020304, 32'h05060708, 32'h0, CFU_ERROR_STATE, 1);
        txn("wrstat_off", 10'd1022, 3'd3, 32'h0, 32'h0, 32'h101, CFU_OK, 1);
        txn("err_off", 10'd0, 3'd3, 32'h01020304, 32'h05060708, 32'h0, CFU_ERROR_OFF, 1);
        txn("err_func", 10'd7, 3'd0, 32'h01020304, 32'h05060708, 32'h0, CFU_ERROR_FUNC, 1);
        txn("keep_acc_s0", 10'd1021, 3'd0, 32'h0, 32'h0, 32'h3FC, CFU_OK, 1);
        txn("keep_stat_s0", 10'd1023, 3'd0, 32'h0, 32'h0, 32'h103, CFU_OK, 1);
        txn("keep_stat_s3", 10'd1023, 3'd3, 32'h0, 32'h0, 32'h100, CFU_OK, 1);

        // Reset during the second BUSY cycle drops the operation.
        @(negedge clk);
        req_func = 10'd0; req_state = 3'd1; req_data0 = 32'h01020304; req_data1 = 32'h05060708;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check_eq("abort_no_resp", 64'(seen), 64'(0));
        txn("abort_rdstate", 10'd1021, 3'd1, 32'h0, 32'h0, 32'h0, CFU_OK, 1);
        txn("abort_rdstat", 10'd1023, 3'd1, 32'h0, 32'h0, 32'h101, CFU_OK, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
